// File: rtl/tag_converter_if.sv
// tag_converter_if: raw tag/wrap inputs and decoded tag outputs of the tag converter
interface tag_converter_if;
  logic [31:0] tag;
  logic [31:0] wrap_count;
  logic [63:0] tagtime;
  logic        valid_tag;
  logic [4:0]  channel;
  logic        rising_edge;
  modport master (output tag, wrap_count, input tagtime, valid_tag, channel, rising_edge);
  modport slave (input tag, wrap_count, output tagtime, valid_tag, channel, rising_edge);
endinterface

// File: rtl/tag_converter.sv
// tag_converter: registers one decoded FPGA-link tag per cycle as absolute time, channel and edge
module tag_converter (
  input logic clk,
  input logic rst,
  tag_converter_if.slave bus
);
  // tagtime is a plain concatenation of wrap, coarse counter and subtime; no carry needed
  always_ff @(posedge clk)
    if (rst) begin
      bus.tagtime <= '0;
      bus.channel <= '0;
      bus.rising_edge <= 1'b0;
      bus.valid_tag <= 1'b0;
    end else begin
      bus.valid_tag <= bus.tag[0];
      if (bus.tag[0]) begin
        bus.tagtime <= {7'b0, bus.wrap_count, bus.tag[31:7]};
        bus.channel <= bus.tag[6:2];
        bus.rising_edge <= bus.tag[1];
      end
    end
endmodule

// File: tb/tb_tag_converter.sv
// tb_tag_converter: directed vectors, literal expectations and a per-cycle arithmetic model check
module tb_tag_converter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;
  logic [63:0] m_time = '0;
  logic [4:0]  m_ch = '0;
  logic        m_re = 1'b0;
  logic        m_valid = 1'b0;
  tag_converter_if bus ();
  tag_converter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: time = wrap * 2^25 + counter * 4096 + subtime
  always @(posedge clk) begin
    armed <= 1'b1;
    if (rst) begin
      m_time <= '0; m_ch <= '0; m_re <= 1'b0; m_valid <= 1'b0;
    end else if (bus.tag % 2 == 1) begin
      m_time <= 64'(bus.wrap_count) * 64'd33554432 + 64'(bus.tag / 524288) * 64'd4096 + 64'((bus.tag / 128) % 4096);
      m_ch <= 5'((bus.tag / 4) % 32);
      m_re <= (bus.tag / 2) % 2 == 1;
      m_valid <= 1'b1;
    end else m_valid <= 1'b0;
  end
  always @(negedge clk)
    if (armed) begin
      chk("model_valid", 64'(bus.valid_tag), 64'(m_valid));
      chk("model_tagtime", bus.tagtime, m_time);
      chk("model_channel", 64'(bus.channel), 64'(m_ch));
      chk("model_edge", 64'(bus.rising_edge), 64'(m_re));
    end
  task automatic cyc(input logic [31:0] t, input logic [31:0] w, input logic r);
    @(negedge clk);
    bus.tag = t; bus.wrap_count = w; rst = r;
    @(posedge clk); #1;
  endtask
  task automatic lit(input string n, input logic v, input logic [63:0] tt, input logic [4:0] c, input logic e);
    chk({n, "_valid"}, 64'(bus.valid_tag), 64'(v));
    chk({n, "_tagtime"}, bus.tagtime, tt);
    chk({n, "_channel"}, 64'(bus.channel), 64'(c));
    chk({n, "_edge"}, 64'(bus.rising_edge), 64'(e));
  endtask
  logic [63:0] prev;
  initial begin
    bus.tag = 32'h0028918F; bus.wrap_count = 32'd1;
    cyc(32'h0028918F, 32'd1, 1'b1);
    cyc(32'h0, 32'd0, 1'b1);
    lit("reset", 1'b0, 64'h0, 5'd0, 1'b0);
    cyc(32'h0028918F, 32'd1, 1'b0);
    lit("basic", 1'b1, 64'h0000_0000_0200_5123, 5'd3, 1'b1);
    cyc(32'h0, 32'd1, 1'b0);
    lit("notag", 1'b0, 64'h0000_0000_0200_5123, 5'd3, 1'b1);
    cyc(32'h0028918E, 32'd5, 1'b0);
    lit("bit0_clear", 1'b0, 64'h0000_0000_0200_5123, 5'd3, 1'b1);
    cyc(32'h0000007D, 32'd0, 1'b0);
    lit("fall31", 1'b1, 64'h0, 5'd31, 1'b0);
    cyc(32'h0, 32'd0, 1'b0);
    lit("fall31_pulse", 1'b0, 64'h0, 5'd31, 1'b0);
    cyc(32'hFFFFFFFF, 32'd0, 1'b0);
    lit("wrap_a", 1'b1, 64'h1FF_FFFF, 5'd31, 1'b1);
    prev = bus.tagtime;
    cyc(32'h00000003, 32'd1, 1'b0);
    lit("wrap_b", 1'b1, 64'h200_0000, 5'd0, 1'b1);
    chk("wrap_increasing", 64'(bus.tagtime > prev), 64'd1);
    cyc(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    lit("max", 1'b1, 64'h01FF_FFFF_FFFF_FFFF, 5'd31, 1'b1);
    cyc(32'h0028918F, 32'd1, 1'b1);
    lit("rst_mid", 1'b0, 64'h0, 5'd0, 1'b0);
    cyc(32'h0000007D, 32'd7, 1'b0);
    lit("post_rst", 1'b1, 64'h0000_0000_0E00_0000, 5'd31, 1'b0);
    for (int i = 0; i < 40; i++) cyc($urandom, $urandom, 1'b0);
    cyc(32'h0, 32'd0, 1'b0);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
